// File: rtl/sha1_ctrl_pkg.sv
// Shared types and constants for the SHA-1 core arbiter.
//   state_e  : arbiter FSM states
//   SHA1_IV  : initial chaining value H0..H4, H0 in the top word
//   BLOCK_W  : message block width
//   DIGEST_W : chaining value / digest width
package sha1_ctrl_pkg;

    localparam int BLOCK_W  = 512;
    localparam int DIGEST_W = 160;

    localparam logic [DIGEST_W-1:0] SHA1_IV =
        160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    typedef enum logic [2:0] {
        ARB   = 3'd0,
        ISSUE = 3'd1,
        RUN   = 3'd2,
        NEXT  = 3'd3,
        RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req     : request vector
//   ptr     : highest-priority index for this decision
//   gnt     : one-hot grant (all zero when nothing requests)
//   gnt_idx : binary index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand;

    // Walk from the farthest offset back to ptr so the closest requester at
    // or above ptr (with wrap) is the last one written and therefore wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/sha1_core_arbiter.sv
// Shares one SHA-1 compression core between NUM_REQ requesters. A message
// (sequence of pre-padded blocks) is granted round-robin and owns the core
// until its last block completes; the chaining value lives here and the
// digest is returned on a valid/ready response channel.
//   clk, reset_n              : clock, synchronous active-low reset
//   req_valid/ready/block/last: per-requester block offer
//   core_start/block/hin      : core command, held from start to done
//   core_done/hout            : core completion and updated chaining value
//   rsp_valid/ready/id/digest/err : digest response
//   busy                      : a message is in progress
//
// state | meaning
// ARB   | pick next requester round-robin, wait for its first block
// ISSUE | pulse core_start, clear watchdog
// RUN   | wait for core_done or watchdog expiry
// NEXT  | wait for the owner's next block (others locked out)
// RESP  | present digest until consumer accepts it
module sha1_core_arbiter
    import sha1_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BLOCK_W-1:0]   req_block,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic                         core_start,
    output logic [BLOCK_W-1:0]           core_block,
    output logic [DIGEST_W-1:0]          core_hin,
    input  logic                         core_done,
    input  logic [DIGEST_W-1:0]          core_hout,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [DIGEST_W-1:0]          rsp_digest,
    output logic                         rsp_err,
    output logic                         busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [BLOCK_W-1:0]  block_q, block_d;
    logic                last_q, last_d;
    logic [DIGEST_W-1:0] chain_q, chain_d;
    logic [WDW-1:0]      wdog_q, wdog_d;
    logic                err_q, err_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [IDW-1:0]      gnt_idx;
    logic [IDW-1:0]      sel_idx;
    logic [BLOCK_W-1:0]  sel_block;
    logic [NUM_REQ-1:0]  owner_oh;
    logic [WDW-1:0]      wdog_inc;
    logic                xfer;
    logic                core_cmd;

    rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign owner_oh  = NUM_REQ'(1) << owner_q;
    assign req_ready = (state_q == ARB)  ? gnt :
                       (state_q == NEXT) ? owner_oh : '0;
    assign xfer      = |(req_valid & req_ready);
    assign sel_idx   = (state_q == NEXT) ? owner_q : gnt_idx;
    assign sel_block = req_block[int'(sel_idx)*BLOCK_W +: BLOCK_W];
    assign wdog_inc  = wdog_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            block_q  <= '0;
            last_q   <= 1'b0;
            chain_q  <= SHA1_IV;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            block_q  <= block_d;
            last_q   <= last_d;
            chain_q  <= chain_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        block_d    = block_q;
        last_d     = last_q;
        chain_d    = chain_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ARB: begin
                if (xfer) begin
                    block_d = sel_block;
                    last_d  = req_last[sel_idx];
                    owner_d = sel_idx;
                    chain_d = SHA1_IV;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                wdog_d     = '0;
                state_d    = RUN;
            end
            RUN: begin
                wdog_d = wdog_inc;
                // A done arriving on the expiry cycle is still accepted.
                if (core_done) begin
                    chain_d = core_hout;
                    state_d = last_q ? RESP : NEXT;
                end else if (wdog_inc == WDW'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            NEXT: begin
                if (xfer) begin
                    block_d = sel_block;
                    last_d  = req_last[sel_idx];
                    state_d = ISSUE;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rr_ptr_d = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    err_d    = 1'b0;
                    state_d  = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Core and response buses read zero outside the states that own them.
    assign core_cmd   = (state_q == ISSUE) || (state_q == RUN);
    assign core_block = core_cmd ? block_q : '0;
    assign core_hin   = core_cmd ? chain_q : '0;
    assign rsp_id     = (state_q == RESP) ? owner_q : '0;
    assign rsp_digest = (state_q == RESP) ? chain_q : '0;
    assign rsp_err    = (state_q == RESP) ? err_q : 1'b0;
    assign busy       = (state_q != ARB);

endmodule
